slot_timer_scheduler: RTL

Time-base controller for the parking lot's per-slot occupancy timers. It owns a single shared minute prescaler running as a synchronous enable, not a derived clock, and keeps an elapsed-minutes register per parking slot. It serialises start/stop/clear commands from the entry/exit logic against the periodic minute sweep, and serves read requests from the fee calculator. It sits between the gate/sensor control FSMs and the billing/display logic.

---
 rtl/slot_timer_pkg.sv | 18 +
 rtl/slot_timer_scheduler_if.sv | 28 ++
 rtl/minute_prescaler.sv | 24 ++
 rtl/slot_timer_scheduler.sv | 130 +++++++++++++
 4 files changed

// File: rtl/slot_timer_pkg.sv
// Shared encodings and constants for the parking-slot timer scheduler.
package slot_timer_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_START = 2'b01,
    OP_STOP  = 2'b10,
    OP_CLEAR = 2'b11
  } cmd_op_t;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } state_t;

  localparam logic [31:0] FAST_DIV = 32'd16;

endpackage

// File: rtl/slot_timer_scheduler_if.sv
// Command and read-port bundle between the gate/billing logic and the slot timer scheduler.
interface slot_timer_scheduler_if #(
  parameter int SLOT_W = 2,
  parameter int MIN_W  = 12
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [SLOT_W-1:0] cmd_slot;
  logic              rd_req;
  logic [SLOT_W-1:0] rd_slot;
  logic              rd_valid;
  logic [MIN_W-1:0]  rd_minutes;
  logic              rd_running;
  logic              rd_ovf;

  modport master (
    output cmd_valid, cmd_op, cmd_slot, rd_req, rd_slot,
    input  cmd_ready, rd_valid, rd_minutes, rd_running, rd_ovf
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_slot, rd_req, rd_slot,
    output cmd_ready, rd_valid, rd_minutes, rd_running, rd_ovf
  );

endinterface

// File: rtl/minute_prescaler.sv
// Free-running divider producing a one-cycle minute enable strobe (not a derived clock).
module minute_prescaler #(
  parameter logic [31:0] DIV = 32'd16
) (
  input  logic clk,
  input  logic reset,
  output logic tick_1min
);

  logic [31:0] count;

  assign tick_1min = (count == DIV - 32'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (tick_1min) begin
      count <= '0;
    end else begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/slot_timer_scheduler.sv
// Per-slot elapsed-minutes timers swept once per minute strobe; commands are held off during a sweep.
// Define SLOT_TIMER_FAST_TICK_EN to fix the minute divisor at FAST_DIV for simulation and board demos.
module slot_timer_scheduler
  import slot_timer_pkg::*;
#(
  parameter int          NUM_SLOTS = 4,
  parameter int          MIN_W     = 12,
  parameter logic [31:0] TICK_DIV  = 32'd2_400_000_000,
  parameter int          SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                   clk,
  input  logic                   reset,
  slot_timer_scheduler_if.slave  bus,
  output logic                   tick_1min,
  output logic                   busy
);

`ifdef SLOT_TIMER_FAST_TICK_EN
  localparam logic [31:0] DIV = FAST_DIV;
`else
  localparam logic [31:0] DIV = TICK_DIV;
`endif

  localparam logic [MIN_W-1:0]  MIN_MAX   = '1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  // A strobe must never land inside a sweep, otherwise a minute would be lost.
  generate
    if (DIV <= 32'(NUM_SLOTS + 1)) begin : g_div_check
      $error("slot_timer_scheduler: divisor must exceed NUM_SLOTS+1");
    end
    if (NUM_SLOTS < 2) begin : g_slot_check
      $error("slot_timer_scheduler: NUM_SLOTS must be at least 2");
    end
  endgenerate

  state_t            state;
  logic              pending;
  logic [SLOT_W-1:0] idx;
  logic [MIN_W-1:0]  minutes [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] running;
  logic [NUM_SLOTS-1:0] ovf;
  logic              cmd_fire;

  minute_prescaler #(.DIV(DIV)) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .tick_1min (tick_1min)
  );

  assign bus.cmd_ready = (state == ST_IDLE) && !pending;
  assign busy          = pending || (state == ST_SWEEP);
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending) begin
            state   <= ST_SWEEP;
            pending <= 1'b0;
            idx     <= '0;
          end else if (tick_1min) begin
            pending <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (idx == LAST_SLOT) begin
            state <= ST_IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sweep and command writes never coincide because commands are only accepted outside a sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        minutes[i] <= '0;
      end
      running <= '0;
      ovf     <= '0;
    end else begin
      if (state == ST_SWEEP && running[idx]) begin
        if (minutes[idx] == MIN_MAX) begin
          ovf[idx] <= 1'b1;
        end else begin
          minutes[idx] <= minutes[idx] + 1'b1;
        end
      end
      if (cmd_fire) begin
        case (cmd_op_t'(bus.cmd_op))
          OP_START: running[bus.cmd_slot] <= 1'b1;
          OP_STOP:  running[bus.cmd_slot] <= 1'b0;
          OP_CLEAR: begin
            minutes[bus.cmd_slot] <= '0;
            running[bus.cmd_slot] <= 1'b0;
            ovf[bus.cmd_slot]     <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rd_valid   <= 1'b0;
      bus.rd_minutes <= '0;
      bus.rd_running <= 1'b0;
      bus.rd_ovf     <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_req;
      if (bus.rd_req) begin
        bus.rd_minutes <= minutes[bus.rd_slot];
        bus.rd_running <= running[bus.rd_slot];
        bus.rd_ovf     <= ovf[bus.rd_slot];
      end
    end
  end

endmodule
